// File: rtl/mat_loader.sv
// Streams an N x N matrix (row-major) into per-processor coefficient RAM banks,
// then the N-element operand vector into the vector buffer, and pulses Done.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for Start; Rx bytes dropped
// LOAD_MAT | each Rx byte written to bank[row] at address col
// LOAD_VEC | each Rx byte written to vector buffer at address idx
// DONE_S   | Done/last Vec_WE visible this cycle; Rx bytes dropped
module mat_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_P      = 8,
  parameter int MAX_SIZE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [3:0]            MAT_SIZE,
  input  logic [DATA_WIDTH-1:0] Rx_data,
  input  logic                  Rx_valid,
  output logic [NUM_P-1:0]      WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  Vec_WE,
  output logic [ADDR_WIDTH-1:0] Vec_ADDR,
  output logic [DATA_WIDTH-1:0] Vec_DATA,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [1:0] {IDLE, LOAD_MAT, LOAD_VEC, DONE_S} state_t;

  localparam logic [3:0] MAX_N = 4'(MAX_SIZE);

  state_t state, next_state;

  logic [3:0] n_reg, row, col, idx;
  logic [3:0] n_last;
  logic       size_ok, accept, mat_last, vec_last;

  logic [NUM_P-1:0]      wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d, vec_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d, vec_data_d;
  logic                  vec_we_d, busy_d, done_d, error_d;

  assign n_last   = n_reg - 4'd1;
  assign size_ok  = (MAT_SIZE != 4'd0) && (MAT_SIZE <= MAX_N);
  assign accept   = (state == IDLE) && Start && size_ok;
  assign mat_last = (row == n_last) && (col == n_last);
  assign vec_last = (idx == n_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = LOAD_MAT;
      LOAD_MAT: if (Rx_valid && mat_last) next_state = LOAD_VEC;
      LOAD_VEC: if (Rx_valid && vec_last) next_state = DONE_S;
      DONE_S:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Address/data hold their last value between strobes; only the strobes are pulses.
  always_comb begin
    wr_en_d    = '0;
    wr_addr_d  = WR_ADDR;
    wr_data_d  = WR_DATA;
    vec_we_d   = 1'b0;
    vec_addr_d = Vec_ADDR;
    vec_data_d = Vec_DATA;
    busy_d     = (next_state != IDLE);
    done_d     = (state == LOAD_VEC) && (next_state == DONE_S);
    error_d    = Error;
    case (state)
      IDLE: if (Start) error_d = !size_ok;
      LOAD_MAT: if (Rx_valid) begin
        wr_en_d   = {{(NUM_P-1){1'b0}}, 1'b1} << row;
        wr_addr_d = ADDR_WIDTH'(col);
        wr_data_d = Rx_data;
      end
      LOAD_VEC: if (Rx_valid) begin
        vec_we_d   = 1'b1;
        vec_addr_d = ADDR_WIDTH'(idx);
        vec_data_d = Rx_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WR_EN    <= '0;
      WR_ADDR  <= '0;
      WR_DATA  <= '0;
      Vec_WE   <= 1'b0;
      Vec_ADDR <= '0;
      Vec_DATA <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
    end else begin
      WR_EN    <= wr_en_d;
      WR_ADDR  <= wr_addr_d;
      WR_DATA  <= wr_data_d;
      Vec_WE   <= vec_we_d;
      Vec_ADDR <= vec_addr_d;
      Vec_DATA <= vec_data_d;
      Busy     <= busy_d;
      Done     <= done_d;
      Error    <= error_d;
    end
  end

  // Counters are cleared on their final byte so they never reach N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_reg <= '0;
      row   <= '0;
      col   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          n_reg <= MAT_SIZE;
          row   <= '0;
          col   <= '0;
          idx   <= '0;
        end
        LOAD_MAT: if (Rx_valid) begin
          if (mat_last) begin
            row <= '0;
            col <= '0;
            idx <= '0;
          end else if (col == n_last) begin
            col <= '0;
            row <= row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end
        LOAD_VEC: if (Rx_valid) begin
          if (vec_last) idx <= '0;
          else          idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_loader.sv
// Directed bench for mat_loader: vector table for short loads, plus hand-written
// sequences for full-size streaming and reset in the middle of a load.
module tb_mat_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start;
  logic [3:0] MAT_SIZE;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic [7:0] WR_EN;
  logic [3:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       Vec_WE;
  logic [3:0] Vec_ADDR;
  logic [7:0] Vec_DATA;
  logic       Busy, Done, Error;

  int checks = 0;
  int errors = 0;

  mat_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_P(8), .MAX_SIZE(8)) dut (
    .clk(clk), .rst(rst), .Start(Start), .MAT_SIZE(MAT_SIZE),
    .Rx_data(Rx_data), .Rx_valid(Rx_valid),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .Vec_WE(Vec_WE), .Vec_ADDR(Vec_ADDR), .Vec_DATA(Vec_DATA),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [3:0] sz;
    logic       v;
    logic [7:0] d;
    logic [7:0] e_wr;
    logic [3:0] e_addr;
    logic [7:0] e_wd;
    logic       e_vwe;
    logic [3:0] e_vaddr;
    logic [7:0] e_vd;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic [3:0] sz, logic v, logic [7:0] d,
                              logic [7:0] e_wr, logic [3:0] e_addr, logic [7:0] e_wd,
                              logic e_vwe, logic [3:0] e_vaddr, logic [7:0] e_vd,
                              logic e_busy, logic e_done, logic e_err);
    vec_t r;
    r.st = st; r.sz = sz; r.v = v; r.d = d;
    r.e_wr = e_wr; r.e_addr = e_addr; r.e_wd = e_wd;
    r.e_vwe = e_vwe; r.e_vaddr = e_vaddr; r.e_vd = e_vd;
    r.e_busy = e_busy; r.e_done = e_done; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic step(input logic st, input logic [3:0] sz, input logic v, input logic [7:0] d);
    Start = st; MAT_SIZE = sz; Rx_valid = v; Rx_data = d;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; Rx_valid = 1'b0;
  endtask

  task automatic chk_out(input string name, input int tag, input vec_t e);
    chk({name, ".wr_en"}, tag, 32'(WR_EN), 32'(e.e_wr));
    if (e.e_wr != 8'h00) begin
      chk({name, ".wr_addr"}, tag, 32'(WR_ADDR), 32'(e.e_addr));
      chk({name, ".wr_data"}, tag, 32'(WR_DATA), 32'(e.e_wd));
    end
    chk({name, ".vec_we"}, tag, 32'(Vec_WE), 32'(e.e_vwe));
    if (e.e_vwe) begin
      chk({name, ".vec_addr"}, tag, 32'(Vec_ADDR), 32'(e.e_vaddr));
      chk({name, ".vec_data"}, tag, 32'(Vec_DATA), 32'(e.e_vd));
    end
    chk({name, ".busy"}, tag, 32'(Busy), 32'(e.e_busy));
    chk({name, ".done"}, tag, 32'(Done), 32'(e.e_done));
    chk({name, ".error"}, tag, 32'(Error), 32'(e.e_err));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".wr_en"},    0, 32'(WR_EN),    0);
    chk({name, ".wr_addr"},  0, 32'(WR_ADDR),  0);
    chk({name, ".wr_data"},  0, 32'(WR_DATA),  0);
    chk({name, ".vec_we"},   0, 32'(Vec_WE),   0);
    chk({name, ".vec_addr"}, 0, 32'(Vec_ADDR), 0);
    chk({name, ".vec_data"}, 0, 32'(Vec_DATA), 0);
    chk({name, ".busy"},     0, 32'(Busy),     0);
    chk({name, ".done"},     0, 32'(Done),     0);
    chk({name, ".error"},    0, 32'(Error),    0);
  endtask

  initial begin
    vec_t e;
    logic [7:0] b;

    //         st sz  v  d      wr    addr wd     vwe va   vd     busy done err
    // basic N=2 load, back-to-back bytes
    tbl.push_back(mk(1, 2, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'h11, 8'h01, 0, 8'h11, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'h12, 8'h01, 1, 8'h12, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'h21, 8'h02, 0, 8'h21, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'h22, 8'h02, 1, 8'h22, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'hA1, 8'h00, 0, 8'h00, 1, 0, 8'hA1, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'hA2, 8'h00, 0, 8'h00, 1, 1, 8'hA2, 1, 1, 0));
    tbl.push_back(mk(0, 2, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    // illegal sizes, then N=1 clears Error
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 9, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h5A, 8'h01, 0, 8'h5A, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h3C, 8'h00, 0, 8'h00, 1, 0, 8'h3C, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    // N=2 with gaps; Start with size 3 mid-load must be ignored
    tbl.push_back(mk(1, 2, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'h11, 8'h01, 0, 8'h11, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'h12, 8'h01, 1, 8'h12, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 3, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 3, 1, 8'h21, 8'h02, 0, 8'h21, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 3, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 3, 1, 8'h22, 8'h02, 1, 8'h22, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 3, 1, 8'hA1, 8'h00, 0, 8'h00, 1, 0, 8'hA1, 1, 0, 0));
    tbl.push_back(mk(0, 3, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 3, 1, 8'hA2, 8'h00, 0, 8'h00, 1, 1, 8'hA2, 1, 1, 0));
    // bytes during DONE and in IDLE are dropped
    tbl.push_back(mk(0, 3, 1, 8'h77, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 8'h78, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    // Start and byte in the same IDLE cycle: byte dropped
    tbl.push_back(mk(1, 1, 1, 8'h99, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h42, 8'h01, 0, 8'h42, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h43, 8'h00, 0, 8'h00, 1, 0, 8'h43, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));

    rst = 1'b0; Start = 1'b0; MAT_SIZE = 4'd0; Rx_data = 8'h00; Rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].sz, tbl[i].v, tbl[i].d);
      chk_out("tbl", i, tbl[i]);
    end

    // full size N=8, 72 bytes streamed with no gaps
    step(1, 8, 0, 8'h00);
    for (int k = 0; k < 72; k++) begin
      b = 8'(k * 3 + 1);
      step(0, 8, 1, b);
      e = mk(0, 8, 1, b, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
      if (k < 64) begin
        e.e_wr = 8'(1 << (k / 8));
        e.e_addr = 4'(k % 8);
        e.e_wd = b;
      end else begin
        e.e_vwe = 1'b1;
        e.e_vaddr = 4'(k - 64);
        e.e_vd = b;
      end
      e.e_done = (k == 71);
      chk_out("full", k, e);
    end
    step(0, 8, 0, 8'h00);
    chk("full.busy_after", 0, 32'(Busy), 0);

    // reset in the middle of an N=3 load
    step(1, 3, 0, 8'h00);
    for (int k = 0; k < 4; k++) step(0, 3, 1, 8'(8'hB0 + k));
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    step(0, 3, 1, 8'hEE);
    chk_out("midrst_idle", 0, mk(0, 3, 1, 8'hEE, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    step(1, 3, 0, 8'h00);
    for (int k = 0; k < 12; k++) begin
      b = 8'(8'hC0 + k);
      step(0, 3, 1, b);
      e = mk(0, 3, 1, b, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
      if (k < 9) begin
        e.e_wr = 8'(1 << (k / 3));
        e.e_addr = 4'(k % 3);
        e.e_wd = b;
      end else begin
        e.e_vwe = 1'b1;
        e.e_vaddr = 4'(k - 9);
        e.e_vd = b;
      end
      e.e_done = (k == 11);
      chk_out("restart", k, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_loader.md
# mat_loader

Matrix/vector loader for the matrix-vector multiplier datapath. It receives a byte stream from the UART receiver and writes an N×N matrix row-by-row into the per-processor coefficient RAMs. Each P_block later reads its row back through its own RAM address port. It then writes the N-element operand vector into the vector buffer and pulses Done so the control FSM can raise Enable on the processors.

## Interface
Parameters:
- DATA_WIDTH, 8, width of matrix and vector elements
- ADDR_WIDTH, 4, width of RAM and vector buffer addresses
- NUM_P, 8, number of processor blocks, one RAM bank each
- MAX_SIZE, 8, largest legal MAT_SIZE

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- Start  input  1  single-cycle request to begin a load; honoured only in IDLE
- MAT_SIZE  input  4  matrix order N; sampled on an accepted Start
- Rx_data  input  DATA_WIDTH  byte from UART receiver
- Rx_valid  input  1  Rx_data valid, one cycle per byte
- WR_EN  output  NUM_P  one-hot write strobe, one bit per processor RAM bank
- WR_ADDR  output  ADDR_WIDTH  RAM write address (column index)
- WR_DATA  output  DATA_WIDTH  RAM write data
- Vec_WE  output  1  vector buffer write strobe
- Vec_ADDR  output  ADDR_WIDTH  vector buffer address
- Vec_DATA  output  DATA_WIDTH  vector buffer write data
- Busy  output  1  high while a load is in progress (state ≠ IDLE)
- Done  output  1  one-cycle pulse when the load completes
- Error  output  1  sticky flag set by a Start with an illegal MAT_SIZE

## Operation
- Stream order: N×N matrix bytes in row-major order, then N vector bytes. Total is N²+N bytes.
- FSM states and transitions:
  - IDLE → LOAD_MAT on Start with 1 ≤ MAT_SIZE ≤ MAX_SIZE. N is latched; row and col counters are cleared; Error is cleared.
  - IDLE stays IDLE on Start with MAT_SIZE = 0 or MAT_SIZE > MAX_SIZE. Error is set.
  - LOAD_MAT handling of each Rx_valid byte at (row, col):
    - WR_EN[row] is asserted, with WR_ADDR = col and WR_DATA = byte.
    - col increments. When col = N−1, col wraps to 0 and row increments.
    - After the byte at (N−1, N−1), the FSM moves to LOAD_VEC and the index counter is cleared.
  - LOAD_VEC handling of each Rx_valid byte:
    - Vec_WE is asserted, with Vec_ADDR = idx and Vec_DATA = byte.
    - idx increments. After idx = N−1, the FSM moves to DONE.
  - DONE: Done = 1 for exactly one cycle, then IDLE.
- Ignored and dropped inputs:
  - Start in any state other than IDLE.
  - Rx_valid in IDLE or DONE.
- Start and Rx_valid in the same IDLE cycle: Start is honoured and the byte is dropped.
- Write address widths:
  - WR_ADDR and Vec_ADDR carry the counter value zero-extended to ADDR_WIDTH.
  - Counters never exceed N−1.
- MAT_SIZE changes after Start have no effect until the next accepted Start.

## Timing
- Reset values: WR_EN = 0, WR_ADDR = 0, WR_DATA = 0, Vec_WE = 0, Vec_ADDR = 0, Vec_DATA = 0, Busy = 0, Done = 0, Error = 0. State is IDLE and all counters are 0.
- All outputs are registered.
- Write latency is 1 cycle: a byte with Rx_valid at edge k produces its strobe, address and data during cycle k+1.
- Each strobe lasts exactly one cycle.
- Back-to-back Rx_valid is supported, giving one write per cycle with no bubbles.
- Done coincides with the cycle in which the final Vec_WE is high. Busy is also still high in that cycle and falls on the following cycle.
- Busy rises the cycle after an accepted Start.
- Reset mid-load: on rst low, everything returns asynchronously to reset values. Partially written RAM contents are left as they are, and no Done is produced. A fresh Start is required to load again.
- Error stays high until the next accepted Start or reset.

## Test plan
- Basic load: N=2, Start, then bytes 0x11, 0x12, 0x21, 0x22, 0xA1, 0xA2 on consecutive cycles. Required writes:
  - WR_EN=0x01 at addresses 0/1 with data 0x11/0x12.
  - WR_EN=0x02 at addresses 0/1 with data 0x21/0x22.
  - Vec_WE at addresses 0/1 with data 0xA1/0xA2.
  - Done pulses in the same cycle as the 0xA2 write; Busy low one cycle later.
- Full size with streaming: N=8, 72 bytes with Rx_valid high continuously from cycle 0. Required response:
  - 72 writes in cycles 1–72, each hitting the correct bank and address.
  - The last matrix write is WR_EN=0x80 at address 7.
  - Done is high in cycle 72.
- Illegal sizes: Start with MAT_SIZE=0, then Start with MAT_SIZE=9. Error goes high and Busy stays 0 in both cases. A following Start with N=1 clears Error, and bytes 0x5A, 0x3C give WR_EN=0x01 at address 0 with data 0x5A, then Vec_WE at address 0 with data 0x3C, plus Done.
- Gaps and protocol violations: N=2 with idle cycles between Rx_valid pulses gives writes identical to the basic load test. Additionally:
  - A Start issued during LOAD_MAT with MAT_SIZE=3 is ignored; N stays 2.
  - An Rx_valid in the cycle after Done produces no write.
- Reset mid-load: N=3, rst driven low after 4 bytes. All outputs go to 0 immediately and Busy = 0. A subsequent Start with N=3 restarts at row 0, column 0.
